soc_boot_sequencer: RTL and testbench

Synthesizable boot and run controller that sits between a program-image source and `risc_v_soc`. It streams an instruction image into the SoC instruction ROM write port while holding the core in reset. It then releases the core after a programmable reset window and supervises execution with a cycle budget, a halt request and parametrised pipeline-hold injection. This replaces the fixed reset/hold/stop sequencing with one reusable, parametrised block.

---
 rtl/soc_boot_pkg.sv | 27 ++
 rtl/hold_injector.sv | 59 +++++
 rtl/soc_boot_sequencer.sv | 155 +++++++++++++++
 tb/tb_soc_boot_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_boot_pkg.sv
// ============================================================================
// Module      : soc_boot_pkg
// Description : Shared state encoding and counter widths for the boot
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package soc_boot_pkg;

    localparam int C_RUN_CNT_W = 32;

    localparam logic [1:0] C_ST_LOAD  = 2'd0;
    localparam logic [1:0] C_ST_RESET = 2'd1;
    localparam logic [1:0] C_ST_RUN   = 2'd2;
    localparam logic [1:0] C_ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_LOAD  = C_ST_LOAD,
        ST_RESET = C_ST_RESET,
        ST_RUN   = C_ST_RUN,
        ST_DONE  = C_ST_DONE
    } boot_state_t;

endpackage

`default_nettype wire

// File: rtl/hold_injector.sv
// ============================================================================
// Module      : hold_injector
// Description : Periodic hold-window generator, phase-aligned to RUN entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hold_injector #(
    parameter int HOLD_PERIOD = 0,
    parameter int HOLD_LEN    = 1
) (
    input  logic clk_100MHz,
    input  logic arst,
    input  logic enable,
    output logic inj_hold
);

    generate
        if (HOLD_PERIOD == 0) begin : g_disabled
            logic w_unused_inputs;
            assign w_unused_inputs = ^{clk_100MHz, arst, enable};
            assign inj_hold        = 1'b0;
        end else begin : g_enabled
            localparam int PH_W = (HOLD_PERIOD > 1) ? $clog2(HOLD_PERIOD) : 1;
            localparam logic [PH_W-1:0] C_PH_LAST = PH_W'(HOLD_PERIOD - 1);
            localparam logic [PH_W:0]   C_LEN     = (PH_W + 1)'(HOLD_LEN);
            localparam logic            C_INJ_IDLE = (HOLD_LEN > 0);

            logic [PH_W-1:0] r_phase;
            logic [PH_W-1:0] w_phase_nxt;
            logic            r_inj;
            logic            w_inj_nxt;

            // The flag is decoded from the next phase so it lines up with RUN cycle numbering.
            always_comb begin
                w_phase_nxt = '0;
                if (enable) begin
                    w_phase_nxt = (r_phase == C_PH_LAST) ? '0 : r_phase + PH_W'(1);
                end
                w_inj_nxt = ({1'b0, w_phase_nxt} < C_LEN);
            end

            always_ff @(posedge clk_100MHz or posedge arst) begin
                if (arst) begin
                    r_phase <= '0;
                    r_inj   <= C_INJ_IDLE;
                end else begin
                    r_phase <= w_phase_nxt;
                    r_inj   <= w_inj_nxt;
                end
            end

            assign inj_hold = r_inj;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/soc_boot_sequencer.sv
// ============================================================================
// Module      : soc_boot_sequencer
// Description : Streams a program image into ROM, sequences core reset and
//               supervises the run with budget, halt and hold injection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_boot_sequencer
    import soc_boot_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int RST_CYCLES  = 2,
    parameter int RUN_LIMIT   = 400,
    parameter int HOLD_PERIOD = 0,
    parameter int HOLD_LEN    = 1
) (
    input  logic                   clk_100MHz,
    input  logic                   arst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [DATA_W-1:0]      load_data,
    input  logic                   load_last,
    output logic                   rom_we,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic [DATA_W-1:0]      rom_wdata,
    output logic                   core_rst_n,
    input  logic                   ext_hold,
    output logic                   hold,
    input  logic                   halt_req,
    input  logic                   restart,
    output logic [C_RUN_CNT_W-1:0] run_cycles,
    output logic [1:0]             state,
    output logic                   done,
    output logic                   timeout
);

    localparam logic [ADDR_W-1:0]      C_PTR_LAST   = '1;
    localparam logic [31:0]            C_RST_CYCLES = 32'(RST_CYCLES);
    localparam logic [C_RUN_CNT_W-1:0] C_RUN_LIMIT  = C_RUN_CNT_W'(RUN_LIMIT);

    boot_state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0]      r_ptr, w_ptr_nxt;
    logic [31:0]            r_rst_cnt, w_rst_cnt_nxt;
    logic [C_RUN_CNT_W-1:0] r_run_cycles, w_run_nxt, w_run_sat;
    logic                   r_timeout, w_timeout_nxt;
    logic                   w_accept;
    logic                   w_inj_hold;

    hold_injector #(
        .HOLD_PERIOD (HOLD_PERIOD),
        .HOLD_LEN    (HOLD_LEN)
    ) u_hold_injector (
        .clk_100MHz (clk_100MHz),
        .arst       (arst),
        .enable     (r_state == ST_RUN),
        .inj_hold   (w_inj_hold)
    );

    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            r_state      <= ST_LOAD;
            r_ptr        <= '0;
            r_rst_cnt    <= '0;
            r_run_cycles <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_rst_cnt    <= w_rst_cnt_nxt;
            r_run_cycles <= w_run_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_accept      = load_valid & (r_state == ST_LOAD);
        w_run_sat     = (&r_run_cycles) ? r_run_cycles : r_run_cycles + C_RUN_CNT_W'(1);
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_rst_cnt_nxt = r_rst_cnt;
        w_run_nxt     = r_run_cycles;
        w_timeout_nxt = r_timeout;

        if (restart) begin
            w_state_nxt   = ST_LOAD;
            w_ptr_nxt     = '0;
            w_rst_cnt_nxt = '0;
            w_run_nxt     = '0;
            w_timeout_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        // Pointer parks at the last address; a full ROM is an implicit last beat.
                        if (r_ptr != C_PTR_LAST) begin
                            w_ptr_nxt = r_ptr + ADDR_W'(1);
                        end
                        if (load_last || (r_ptr == C_PTR_LAST)) begin
                            w_state_nxt   = ST_RESET;
                            w_rst_cnt_nxt = C_RST_CYCLES;
                        end
                    end
                end
                ST_RESET: begin
                    if (r_rst_cnt <= 32'd1) begin
                        w_state_nxt   = ST_RUN;
                        w_rst_cnt_nxt = '0;
                        w_run_nxt     = '0;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt - 32'd1;
                    end
                end
                ST_RUN: begin
                    w_run_nxt = w_run_sat;
                    if (halt_req) begin
                        w_state_nxt   = ST_DONE;
                        w_timeout_nxt = 1'b0;
                    end else if ((RUN_LIMIT != 0) && (w_run_sat == C_RUN_LIMIT)) begin
                        w_state_nxt   = ST_DONE;
                        w_timeout_nxt = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_LOAD;
                end
            endcase
        end
    end

    always_comb begin
        load_ready = (r_state == ST_LOAD);
        rom_we     = w_accept;
        rom_addr   = r_ptr;
        rom_wdata  = load_data;
        core_rst_n = (r_state == ST_RUN) || (r_state == ST_DONE);
        done       = (r_state == ST_DONE);
        timeout    = r_timeout;
        run_cycles = r_run_cycles;
        state      = r_state;
        hold       = 1'b0;
        if (r_state == ST_RUN) begin
            hold = ext_hold | w_inj_hold;
        end else if (r_state == ST_DONE) begin
            hold = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_soc_boot_sequencer.sv
// ============================================================================
// Module      : tb_soc_boot_sequencer
// Description : Two differently parametrised sequencers driven by shared
//               stimulus and compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soc_boot_sequencer;

    logic        clk_100MHz = 1'b0;
    logic        arst       = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_last  = 1'b0;
    logic [31:0] load_data  = '0;
    logic        ext_hold   = 1'b0;
    logic        halt_req   = 1'b0;
    logic        restart    = 1'b0;

    logic        a_load_ready, a_rom_we, a_core_rst_n, a_hold, a_done, a_timeout;
    logic [3:0]  a_rom_addr;
    logic [31:0] a_rom_wdata, a_run_cycles;
    logic [1:0]  a_state;
    logic        b_load_ready, b_rom_we, b_core_rst_n, b_hold, b_done, b_timeout;
    logic [1:0]  b_rom_addr;
    logic [31:0] b_rom_wdata, b_run_cycles;
    logic [1:0]  b_state;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state: mode 0..3, write pointer, reset cycles left, RUN cycle count.
    int      m_mode [2];
    int      m_ptr  [2];
    int      m_left [2];
    longint  m_runc [2];
    bit      m_tmo  [2];

    always #5 clk_100MHz = ~clk_100MHz;

    soc_boot_sequencer #(
        .ADDR_W(4), .DATA_W(32), .RST_CYCLES(2), .RUN_LIMIT(20), .HOLD_PERIOD(8), .HOLD_LEN(2)
    ) u_dut_a (
        .clk_100MHz(clk_100MHz), .arst(arst), .load_valid(load_valid), .load_ready(a_load_ready),
        .load_data(load_data), .load_last(load_last), .rom_we(a_rom_we), .rom_addr(a_rom_addr),
        .rom_wdata(a_rom_wdata), .core_rst_n(a_core_rst_n), .ext_hold(ext_hold), .hold(a_hold),
        .halt_req(halt_req), .restart(restart), .run_cycles(a_run_cycles), .state(a_state),
        .done(a_done), .timeout(a_timeout)
    );

    soc_boot_sequencer #(
        .ADDR_W(2), .DATA_W(32), .RST_CYCLES(1), .RUN_LIMIT(10), .HOLD_PERIOD(0), .HOLD_LEN(1)
    ) u_dut_b (
        .clk_100MHz(clk_100MHz), .arst(arst), .load_valid(load_valid), .load_ready(b_load_ready),
        .load_data(load_data), .load_last(load_last), .rom_we(b_rom_we), .rom_addr(b_rom_addr),
        .rom_wdata(b_rom_wdata), .core_rst_n(b_core_rst_n), .ext_hold(ext_hold), .hold(b_hold),
        .halt_req(halt_req), .restart(restart), .run_cycles(b_run_cycles), .state(b_state),
        .done(b_done), .timeout(b_timeout)
    );

    function automatic int p_depth(int d); return (d == 0) ? 16 : 4;  endfunction
    function automatic int p_rst(int d);   return (d == 0) ? 2  : 1;  endfunction
    function automatic int p_limit(int d); return (d == 0) ? 20 : 10; endfunction
    function automatic int p_per(int d);   return (d == 0) ? 8  : 0;  endfunction
    function automatic int p_len(int d);   return (d == 0) ? 2  : 1;  endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_ptr[d] = 0; m_left[d] = 0; m_runc[d] = 0; m_tmo[d] = 1'b0;
        end
    endtask

    task automatic check_outputs(input int d);
        string       p;
        logic [31:0] o_ready, o_we, o_addr, o_wdata, o_rstn, o_hold, o_runc, o_state, o_done, o_tmo;
        logic        e_hold;
        p = (d == 0) ? "a" : "b";
        if (d == 0) begin
            o_ready = 32'(a_load_ready); o_we = 32'(a_rom_we); o_addr = 32'(a_rom_addr);
            o_wdata = a_rom_wdata; o_rstn = 32'(a_core_rst_n); o_hold = 32'(a_hold);
            o_runc = a_run_cycles; o_state = 32'(a_state); o_done = 32'(a_done); o_tmo = 32'(a_timeout);
        end else begin
            o_ready = 32'(b_load_ready); o_we = 32'(b_rom_we); o_addr = 32'(b_rom_addr);
            o_wdata = b_rom_wdata; o_rstn = 32'(b_core_rst_n); o_hold = 32'(b_hold);
            o_runc = b_run_cycles; o_state = 32'(b_state); o_done = 32'(b_done); o_tmo = 32'(b_timeout);
        end
        if (m_mode[d] == 2)
            e_hold = ext_hold || ((p_per(d) != 0) && ((m_runc[d] % p_per(d)) < p_len(d)));
        else
            e_hold = (m_mode[d] == 3);
        chk({p, "_state"},      o_state, 32'(m_mode[d]));
        chk({p, "_load_ready"}, o_ready, 32'(m_mode[d] == 0));
        chk({p, "_rom_we"},     o_we,    32'(load_valid && (m_mode[d] == 0)));
        chk({p, "_core_rst_n"}, o_rstn,  32'(m_mode[d] >= 2));
        chk({p, "_hold"},       o_hold,  32'(e_hold));
        chk({p, "_run_cycles"}, o_runc,  32'(m_runc[d]));
        chk({p, "_done"},       o_done,  32'(m_mode[d] == 3));
        chk({p, "_timeout"},    o_tmo,   32'(m_tmo[d]));
        if (m_mode[d] == 0) chk({p, "_rom_addr"}, o_addr, 32'(m_ptr[d]));
        if (load_valid && (m_mode[d] == 0)) chk({p, "_rom_wdata"}, o_wdata, load_data);
    endtask

    task automatic model_advance(input int d);
        longint n;
        if (restart) begin
            m_mode[d] = 0; m_ptr[d] = 0; m_left[d] = 0; m_runc[d] = 0; m_tmo[d] = 1'b0;
        end else begin
            case (m_mode[d])
                0: if (load_valid) begin
                    if (load_last || (m_ptr[d] == p_depth(d) - 1)) begin
                        m_mode[d] = 1;
                        m_left[d] = p_rst(d);
                    end
                    if (m_ptr[d] != p_depth(d) - 1) m_ptr[d]++;
                end
                1: begin
                    m_left[d]--;
                    if (m_left[d] == 0) begin
                        m_mode[d] = 2;
                        m_runc[d] = 0;
                    end
                end
                2: begin
                    n = m_runc[d] + 1;
                    m_runc[d] = n;
                    if (halt_req) begin
                        m_mode[d] = 3; m_tmo[d] = 1'b0;
                    end else if (n == longint'(p_limit(d))) begin
                        m_mode[d] = 3; m_tmo[d] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic cycle();
        @(negedge clk_100MHz);
        check_outputs(0);
        check_outputs(1);
        model_advance(0);
        model_advance(1);
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic run_until(input int d, input int target, input int max_cyc);
        int n = 0;
        while (!(m_mode[d] == 2 && m_runc[d] == target) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk((d == 0) ? "a_reach_run_cycle" : "b_reach_run_cycle",
            (d == 0) ? a_run_cycles : b_run_cycles, 32'(target));
    endtask

    task automatic run_until_done(input int d, input int max_cyc);
        int n = 0;
        while (m_mode[d] != 3 && n < max_cyc) begin
            cycle();
            n++;
        end
        chk((d == 0) ? "a_reach_done" : "b_reach_done", 32'((d == 0) ? a_done : b_done), 32'd1);
    endtask

    task automatic load_words(input int count, input bit with_last);
        for (int i = 0; i < count; i++) begin
            load_valid = 1'b1;
            load_data  = $urandom;
            load_last  = with_last && (i == count - 1);
            cycle();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic do_arst();
        arst = 1'b1;
        #1;
        chk("a_arst_state", 32'(a_state), 32'd0);
        chk("a_arst_core_rst_n", 32'(a_core_rst_n), 32'd0);
        chk("a_arst_run_cycles", a_run_cycles, 32'd0);
        chk("b_arst_state", 32'(b_state), 32'd0);
        reset_model();
        #1;
        arst = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        cycle();
        restart = 1'b0;
    endtask

    logic [31:0] words [4];

    initial begin
        words[0] = 32'h13; words[1] = 32'h93; words[2] = 32'h113; words[3] = 32'h193;
        reset_model();
        #2;
        check_outputs(0);
        check_outputs(1);
        @(posedge clk_100MHz);
        #1;
        arst = 1'b0;

        // Four-word image with load_last on the final beat.
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = (i == 3);
            cycle();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("a_ready_after_last", 32'(a_load_ready), 32'd0);
        chk("a_rst_n_held", 32'(a_core_rst_n), 32'd0);
        cycle();
        chk("a_rst_n_one_cycle", 32'(a_core_rst_n), 32'd0);
        cycle();
        chk("a_rst_n_two_cycles", 32'(a_core_rst_n), 32'd1);

        // External hold pulse at RUN cycle 5, then budget expiry on both instances.
        run_until(0, 5, 20);
        ext_hold = 1'b1;
        #1;
        chk("a_ext_hold_cycle5", 32'(a_hold), 32'd1);
        cycle();
        ext_hold = 1'b0;
        run_until_done(0, 40);
        chk("a_budget_timeout", 32'(a_timeout), 32'd1);
        chk("a_budget_cycles", a_run_cycles, 32'd20);
        chk("b_budget_timeout", 32'(b_timeout), 32'd1);
        chk("b_budget_cycles", b_run_cycles, 32'd10);
        chk("b_done_hold", 32'(b_hold), 32'd1);
        repeat (3) cycle();
        pulse_restart();
        chk("a_restart_state", 32'(a_state), 32'd0);

        // ROM full on the 2-bit instance: 4th beat is an implicit last; 5th is refused.
        load_words(4, 1'b0);
        chk("b_full_state", 32'(b_state), 32'd1);
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        #1;
        chk("b_full_no_we", 32'(b_rom_we), 32'd0);
        cycle();
        load_words(1, 1'b1);

        // Halt arriving in the very cycle the budget expires.
        run_until(1, 9, 20);
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        chk("b_halt_wins_timeout", 32'(b_timeout), 32'd0);
        chk("b_halt_wins_done", 32'(b_done), 32'd1);
        chk("b_halt_cycles", b_run_cycles, 32'd10);
        pulse_restart();

        // Asynchronous reset at RUN cycle 3, reload from address 0, then restart from DONE.
        load_words(2, 1'b1);
        run_until(0, 3, 20);
        do_arst();
        load_valid = 1'b1;
        load_data  = 32'h0000_0513;
        load_last  = 1'b1;
        #1;
        chk("a_reload_addr0", 32'(a_rom_addr), 32'd0);
        cycle();
        load_valid = 1'b0;
        load_last  = 1'b0;
        run_until_done(0, 40);
        pulse_restart();
        chk("a_restart_done_state", 32'(a_state), 32'd0);
        chk("a_restart_done_rst_n", 32'(a_core_rst_n), 32'd0);
        chk("a_restart_done_cycles", a_run_cycles, 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_last  = ($urandom_range(0, 4) == 0);
            load_data  = $urandom;
            ext_hold   = ($urandom_range(0, 4) == 0);
            halt_req   = ($urandom_range(0, 24) == 0);
            restart    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 149) == 0) do_arst();
            cycle();
        end
        restart = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
